// File: rtl/gpio_prime_engine_pkg.sv
// Shared types and default register map for the GPIO prime engine.
`timescale 1ns/1ps
package gpio_prime_pkg;

  // Externally visible status, encoded as read back through S[1:0]
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Internal search sub-phase while BUSY
  typedef enum logic {
    PH_CHECK = 1'b0,
    PH_WAIT  = 1'b1
  } phase_t;

  localparam logic [15:0] DEF_ADDR_BASE = 16'h0000;
  localparam logic [15:0] DEF_OFF_A     = 16'h00C8;
  localparam logic [15:0] DEF_OFF_W     = 16'h00D8;
  localparam logic [15:0] DEF_OFF_S     = 16'h00E0;
  localparam logic [15:0] DEF_OFF_C     = 16'h00F0;

endpackage

// File: rtl/gpio_prime_engine_seq_mod.sv
// Sequential restoring remainder unit: rem = dividend % divisor.
// One quotient bit per cycle; done pulses exactly W+1 cycles after start.
`timescale 1ns/1ps
module seq_mod #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rem
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_sh;
  logic [W-1:0]  div_r;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic [W:0]    diff;

  // Partial remainder shifted left with the next dividend bit; the top bit
  // of the difference is the borrow that decides whether to restore.
  assign trial = {rem, quo_sh[W-1]};
  assign diff  = trial - {1'b0, div_r};

  // W shift/subtract steps after loading, then one cycle to raise done
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      rem    <= '0;
      quo_sh <= '0;
      div_r  <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        busy   <= 1'b1;
        quo_sh <= dividend;
        div_r  <= divisor;
        rem    <= '0;
        cnt    <= CW'(W);
      end else if (busy) begin
        if (cnt != '0) begin
          rem    <= diff[W] ? trial[W-1:0] : diff[W-1:0];
          quo_sh <= quo_sh << 1;
          cnt    <= cnt - 1'b1;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_prime_engine.sv
// GPIO-emulator prime peripheral: software writes index A, the engine finds
// the A-th prime by trial division and exposes it as W (and on gpio_out).
`timescale 1ns/1ps
module gpio_prime_engine
  import gpio_prime_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          A_WIDTH    = 10,
  parameter logic [15:0] ADDR_BASE  = DEF_ADDR_BASE,
  parameter logic [15:0] OFF_A      = DEF_OFF_A,
  parameter logic [15:0] OFF_W      = DEF_OFF_W,
  parameter logic [15:0] OFF_S      = DEF_OFF_S,
  parameter logic [15:0] OFF_C      = DEF_OFF_C
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           saddress,
  input  logic                  srd,
  input  logic                  swr,
  input  logic [DATA_WIDTH-1:0] sdata_in,
  output logic [DATA_WIDTH-1:0] sdata_out,
  input  logic                  gpio_latch,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_in_s_insp,
  output logic [DATA_WIDTH-1:0] gpio_out
);

  localparam logic [15:0] ADDR_A = ADDR_BASE + OFF_A;
  localparam logic [15:0] ADDR_W = ADDR_BASE + OFF_W;
  localparam logic [15:0] ADDR_S = ADDR_BASE + OFF_S;
  localparam logic [15:0] ADDR_C = ADDR_BASE + OFF_C;

  state_t                state, state_next;
  phase_t                phase, phase_next;
  logic [A_WIDTH-1:0]    a_reg, a_next, c_reg, c_next, c_plus;
  logic [DATA_WIDTH-1:0] w_reg, w_next, gout_next;
  logic [DATA_WIDTH-1:0] n_reg, n_next, d_reg, d_next;
  // d*d is at most one bit wider than the candidate while searching
  logic [DATA_WIDTH:0]   dsq_reg, dsq_next;
  logic                  wr_a, adv_n;
  logic                  mod_start, mod_busy, mod_done;
  logic [DATA_WIDTH-1:0] mod_rem;
  logic                  latch_prev;

  assign wr_a   = swr && (saddress == ADDR_A);
  assign c_plus = c_reg + 1'b1;

  seq_mod #(.W(DATA_WIDTH)) u_seq_mod (
    .clk      (clk),
    .reset    (reset),
    .start    (mod_start),
    .abort    (wr_a),
    .dividend (n_reg),
    .divisor  (d_reg),
    .busy     (mod_busy),
    .done     (mod_done),
    .rem      (mod_rem)
  );

  // Next-state logic for the search FSM and its datapath registers
  always_comb begin
    state_next = state;
    phase_next = phase;
    a_next     = a_reg;
    c_next     = c_reg;
    w_next     = w_reg;
    gout_next  = gpio_out;
    n_next     = n_reg;
    d_next     = d_reg;
    dsq_next   = dsq_reg;
    mod_start  = 1'b0;
    adv_n      = 1'b0;

    if (state == ST_BUSY) begin
      if (phase == PH_CHECK) begin
        if (dsq_reg > {1'b0, n_reg}) begin
          c_next = c_plus;
          if (c_plus == a_reg) begin
            w_next     = n_reg;
            gout_next  = n_reg;
            state_next = ST_DONE;
          end else begin
            adv_n = 1'b1;
          end
        end else begin
          mod_start  = 1'b1;
          phase_next = PH_WAIT;
        end
      end else if (mod_done && !mod_busy) begin
        phase_next = PH_CHECK;
        if (mod_rem == '0) begin
          adv_n = 1'b1;
        end else begin
          d_next   = d_reg + 1'b1;
          dsq_next = dsq_reg + {d_reg, 1'b1};
        end
      end
    end

    // Move to the next candidate, restarting trial division at d=2
    if (adv_n) begin
      if (&n_reg) begin
        state_next = ST_ERROR;
      end else begin
        n_next   = n_reg + 1'b1;
        d_next   = DATA_WIDTH'(2);
        dsq_next = (DATA_WIDTH + 1)'(4);
      end
    end

    // A write restarts the search from scratch in any state
    if (wr_a) begin
      a_next     = sdata_in[A_WIDTH-1:0];
      c_next     = '0;
      n_next     = DATA_WIDTH'(2);
      d_next     = DATA_WIDTH'(2);
      dsq_next   = (DATA_WIDTH + 1)'(4);
      phase_next = PH_CHECK;
      mod_start  = 1'b0;
      state_next = (sdata_in[A_WIDTH-1:0] == '0) ? ST_ERROR : ST_BUSY;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      phase    <= PH_CHECK;
      a_reg    <= '0;
      c_reg    <= '0;
      w_reg    <= '0;
      gpio_out <= '0;
      n_reg    <= '0;
      d_reg    <= '0;
      dsq_reg  <= '0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      a_reg    <= a_next;
      c_reg    <= c_next;
      w_reg    <= w_next;
      gpio_out <= gout_next;
      n_reg    <= n_next;
      d_reg    <= d_next;
      dsq_reg  <= dsq_next;
    end
  end

  // Registered bus read; sees register values from before any same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      sdata_out <= '0;
    end else if (srd) begin
      case (saddress)
        ADDR_A:  sdata_out <= DATA_WIDTH'(a_reg);
        ADDR_W:  sdata_out <= w_reg;
        ADDR_S:  sdata_out <= DATA_WIDTH'(state);
        ADDR_C:  sdata_out <= DATA_WIDTH'(c_reg);
        default: sdata_out <= '0;
      endcase
    end
  end

  // Capture gpio_in on a rising edge of gpio_latch
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_prev     <= 1'b0;
      gpio_in_s_insp <= '0;
    end else begin
      latch_prev <= gpio_latch;
      if (gpio_latch && !latch_prev) begin
        gpio_in_s_insp <= gpio_in;
      end
    end
  end

endmodule

// File: tb/tb_gpio_prime_engine.sv
// Directed + randomized bench for gpio_prime_engine with an arithmetic prime model.
`timescale 1ns/1ps
module tb_gpio_prime_engine;

  localparam logic [15:0] ADDR_A = 16'h00C8;
  localparam logic [15:0] ADDR_W = 16'h00D8;
  localparam logic [15:0] ADDR_S = 16'h00E0;
  localparam logic [15:0] ADDR_C = 16'h00F0;
  localparam int          BUDGET = 60000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_in_s_insp;
  logic [31:0] gpio_out;

  int checks = 0;
  int errors = 0;

  gpio_prime_engine dut (
    .clk            (clk),
    .reset          (reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_latch     (gpio_latch),
    .gpio_in        (gpio_in),
    .gpio_in_s_insp (gpio_in_s_insp),
    .gpio_out       (gpio_out)
  );

  always #5 clk = ~clk;

  // Reference: the a-th prime by plain trial division
  function automatic int nth_prime(input int a);
    int cnt = 0;
    for (int n = 2; n < 1000000; n++) begin
      bit isp = 1'b1;
      for (int d = 2; d * d <= n; d++)
        if (n % d == 0) isp = 1'b0;
      if (isp) begin
        cnt++;
        if (cnt == a) return n;
      end
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] data);
    @(negedge clk);
    saddress = addr;
    srd = 1'b1;
    @(posedge clk);
    #1;
    data = sdata_out;
    srd = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    saddress = addr;
    sdata_in = data;
    swr = 1'b1;
    @(posedge clk);
    #1;
    swr = 1'b0;
  endtask

  // Poll S until it leaves BUSY; note whether ERROR was ever seen
  task automatic wait_done(input string tag, output logic [31:0] s_final, output bit saw_err);
    logic [31:0] v;
    int k;
    saw_err = 1'b0;
    v = 32'd1;
    for (k = 0; k < BUDGET; k++) begin
      rd(ADDR_S, v);
      if (v == 32'd3) saw_err = 1'b1;
      if (v != 32'd1) break;
    end
    s_final = v;
    checks++;
    assert (k < BUDGET) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d cycles expected<%0d", tag, k, BUDGET);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] s;
    bit          saw_err;
    int          a;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_insp", gpio_in_s_insp, 32'h0);
    rd(ADDR_A, v); chk("rst_A", v, 32'd0);
    rd(ADDR_W, v); chk("rst_W", v, 32'd0);
    rd(ADDR_S, v); chk("rst_S", v, 32'd0);
    rd(ADDR_C, v); chk("rst_C", v, 32'd0);
    rd(16'h0010, v); chk("unmapped", v, 32'd0);

    // A=1: first prime
    wr(ADDR_A, 32'd1);
    rd(ADDR_S, v); chk("a1_busy", v, 32'd1);
    wait_done("a1", s, saw_err);
    chk("a1_S", s, 32'd2);
    rd(ADDR_W, v); chk("a1_W", v, 32'd2);
    chk("a1_gpio_out", gpio_out, 32'd2);
    rd(ADDR_C, v); chk("a1_C", v, 32'd1);

    // A=10
    wr(ADDR_A, 32'd10);
    wait_done("a10", s, saw_err);
    chk("a10_S", s, 32'd2);
    rd(ADDR_W, v); chk("a10_W", v, 32'd29);
    rd(ADDR_C, v); chk("a10_C", v, 32'd10);

    // Longer search, no ERROR on the way
    wr(ADDR_A, 32'd50);
    wait_done("a50", s, saw_err);
    chk("a50_S", s, 32'd2);
    chk("a50_no_err", {31'd0, saw_err}, 32'd0);
    rd(ADDR_W, v); chk("a50_W", v, nth_prime(50));
    chk("a50_gpio_out", gpio_out, nth_prime(50));

    // A=0 is an error and leaves W alone; W is not writable
    wr(ADDR_A, 32'd0);
    rd(ADDR_S, v); chk("a0_S", v, 32'd3);
    rd(ADDR_W, v); chk("a0_W_kept", v, nth_prime(50));
    wr(ADDR_W, 32'h55);
    rd(ADDR_W, v); chk("w_write_ignored", v, nth_prime(50));
    rd(ADDR_S, v); chk("error_persists", v, 32'd3);

    // Simultaneous read and write of A returns the old value
    @(negedge clk);
    saddress = ADDR_A;
    sdata_in = 32'd7;
    srd = 1'b1;
    swr = 1'b1;
    @(posedge clk);
    #1;
    v = sdata_out;
    srd = 1'b0;
    swr = 1'b0;
    chk("rdwr_old_A", v, 32'd0);
    rd(ADDR_A, v); chk("rdwr_new_A", v, 32'd7);
    wait_done("a7", s, saw_err);
    rd(ADDR_W, v); chk("a7_W", v, 32'd17);

    // Restart while BUSY; upper data bits ignored when loading A
    wr(ADDR_A, 32'd500);
    repeat (2000) @(posedge clk);
    rd(ADDR_S, v); chk("a500_busy", v, 32'd1);
    rd(ADDR_W, v); chk("a500_W_old", v, 32'd17);
    wr(ADDR_A, 32'hABCD_0003);
    rd(ADDR_A, v); chk("a3_trunc", v, 32'd3);
    rd(ADDR_S, v); chk("a3_busy", v, 32'd1);
    wait_done("a3", s, saw_err);
    chk("a3_S", s, 32'd2);
    rd(ADDR_W, v); chk("a3_W", v, 32'd5);
    rd(ADDR_C, v); chk("a3_C", v, 32'd3);

    // Reset in the middle of a search
    wr(ADDR_A, 32'd500);
    repeat (300) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_gpio_out", gpio_out, 32'd0);
    repeat (50) @(posedge clk);
    rd(ADDR_A, v); chk("mid_rst_A", v, 32'd0);
    rd(ADDR_W, v); chk("mid_rst_W", v, 32'd0);
    rd(ADDR_S, v); chk("mid_rst_S", v, 32'd0);
    rd(ADDR_C, v); chk("mid_rst_C", v, 32'd0);

    // GPIO latch: capture on the rising edge only
    @(negedge clk);
    gpio_in = 32'hDEADBEEF;
    gpio_latch = 1'b1;
    chk("insp_before_edge", gpio_in_s_insp, 32'd0);
    @(posedge clk);
    #1;
    chk("insp_capture", gpio_in_s_insp, 32'hDEADBEEF);
    @(negedge clk);
    gpio_in = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    chk("insp_hold_high", gpio_in_s_insp, 32'hDEADBEEF);
    @(negedge clk);
    gpio_latch = 1'b0;
    @(negedge clk);
    gpio_latch = 1'b1;
    @(posedge clk);
    #1;
    chk("insp_recapture", gpio_in_s_insp, 32'h12345678);
    @(negedge clk);
    gpio_latch = 1'b0;

    // Randomized indices against the model
    for (int i = 0; i < 3; i++) begin
      a = int'($urandom_range(20, 1));
      wr(ADDR_A, a);
      wait_done("rand", s, saw_err);
      chk("rand_S", s, 32'd2);
      rd(ADDR_W, v); chk("rand_W", v, nth_prime(a));
      rd(ADDR_C, v); chk("rand_C", v, a);
      chk("rand_gpio_out", gpio_out, nth_prime(a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
